// File: rtl/burst_ram.sv
// burst_ram: 64-bit word RAM with 4-beat read/write bursts, fixed read latency and init delay
module burst_ram #(
  parameter int DEPTH_BITWIDTH = 21,
  parameter int READ_LATENCY = 12,
  parameter int INIT_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd,
  input  logic                      cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] addr,
  input  logic [63:0]               wr_data,
  input  logic [7:0]                data_mask,
  output logic [63:0]               rd_data,
  output logic                      rd_data_valid,
  output logic                      busy,
  output logic                      init_calib,
  output logic                      cmd_dropped
);
  localparam int AW = DEPTH_BITWIDTH - 3;
  localparam logic [2:0] INIT = 3'd0, IDLE = 3'd1, READ_WAIT = 3'd2, READ_BURST = 3'd3, WRITE_BURST = 3'd4;
  logic [2:0] state;
  logic [7:0] cnt;
  logic [1:0] beat;
  logic [AW-1:0] idx;
  logic [63:0] mem [0:(1<<AW)-1];
  logic accept, we, rd_go, rd_en, unused;
  logic [AW-1:0] w_idx, r_idx;
  assign unused = ^addr[2:0];
  assign busy = state != IDLE;
  assign accept = state == IDLE && cmd_en;
  assign we = !rst && (accept ? cmd : state == WRITE_BURST);
  assign r_idx = idx + AW'(beat);
  assign w_idx = accept ? addr[DEPTH_BITWIDTH-1:3] : r_idx;
  assign rd_go = state == READ_WAIT && cnt == 8'(READ_LATENCY - 1);
  assign rd_en = !rst && (rd_go || state == READ_BURST);
  // byte-masked write of the current beat; contents survive reset
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 8; i++)
        if (!data_mask[i]) mem[w_idx][8*i +: 8] <= wr_data[8*i +: 8];
  end
  // registered read beat, forced to zero whenever no beat is being delivered
  always_ff @(posedge clk) begin
    rd_data_valid <= rd_en;
    rd_data <= rd_en ? mem[r_idx] : 64'h0;
  end
  // command sequencing: init delay, acceptance, latency count and beat stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= 8'd0;
      beat <= 2'd0;
      init_calib <= 1'b0;
      cmd_dropped <= 1'b0;
    end else begin
      cmd_dropped <= cmd_en && busy;
      case (state)
        INIT:
          if (cnt == 8'(INIT_CYCLES - 1)) begin
            state <= IDLE;
            init_calib <= 1'b1;
            cnt <= 8'd0;
          end else cnt <= cnt + 8'd1;
        IDLE:
          if (cmd_en) begin
            idx <= addr[DEPTH_BITWIDTH-1:3];
            cnt <= 8'd0;
            beat <= cmd ? 2'd1 : 2'd0;
            state <= cmd ? WRITE_BURST : READ_WAIT;
          end
        READ_WAIT:
          if (rd_go) begin
            state <= READ_BURST;
            beat <= 2'd1;
          end else cnt <= cnt + 8'd1;
        READ_BURST, WRITE_BURST: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH_BITWIDTH, 21, width of addr (byte address).
- READ_LATENCY, 12, cycles from read command acceptance to first valid beat; legal range 1..63.
- INIT_CYCLES, 8, cycles after reset before init_calib asserts; legal range 1..255.
- Fixed values: beat width 64 bits, 4 beats per burst.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; reset rst is synchronous and active-high, and the clock is clk.
- rst, in, 1, synchronous active-high reset.
- cmd, in, 1, 0: read, 1: write.
- cmd_en, in, 1, cmd and addr are valid this cycle.
- addr, in, DEPTH_BITWIDTH, byte address of burst start.
- wr_data, in, 64, write beat.
- data_mask, in, 8, per-byte mask; 1 = byte not written.
- rd_data, out, 64, read beat.
- rd_data_valid, out, 1, rd_data valid this cycle.
- busy, out, 1, command will not be accepted.
- init_calib, out, 1, initialisation done.
- cmd_dropped, out, 1, one-cycle pulse when cmd_en is ignored.

Function
REQ-003 Storage SHALL be 2^(DEPTH_BITWIDTH-3) words of 64 bits; word index = addr[DEPTH_BITWIDTH-1:3]; addr[2:0] ignored.
REQ-004 Beat k (k=0..3) of a burst SHALL address word (index+k) modulo depth; bursts wrap from the top word to word 0.
REQ-005 States: INIT, IDLE, READ_WAIT, READ_BURST, WRITE_BURST.
REQ-006 INIT: busy=1, init_calib=0; a cycle counter runs; after INIT_CYCLES cycles -> IDLE with init_calib=1; init_calib then stays 1 until reset.
REQ-007 IDLE: busy=0; a clock edge with cmd_en=1 accepts the command and latches the word index.
REQ-008 Write acceptance: wr_data/data_mask at the accepting edge SHALL be beat 0; beats 1..3 SHALL be sampled on the next three edges (WRITE_BURST); then -> IDLE.
REQ-009 Byte i of the target word SHALL be written with wr_data[8i+7:8i] only when data_mask[i]=0.
REQ-010 Read acceptance -> READ_WAIT; rd_data_valid SHALL first be 1 exactly READ_LATENCY cycles after the accepting edge.
REQ-011 READ_BURST: rd_data_valid SHALL be 1 for exactly 4 consecutive cycles carrying beats 0..3 in order; then -> IDLE.
REQ-012 Read data SHALL reflect all writes completed before the read was accepted.
REQ-013 rd_data SHALL be 0 whenever rd_data_valid=0.
REQ-014 busy SHALL be 1 in every state other than IDLE, including the cycle after acceptance.
REQ-015 cmd_en=1 while busy=1 (including INIT) SHALL be ignored: no state change and no memory effect; cmd_dropped SHALL pulse 1 in the following cycle.
REQ-016 A new command SHALL be accepted at the first edge in IDLE; back-to-back bursts have no minimum gap beyond REQ-014.
REQ-017 cmd, addr, wr_data and data_mask are don't-care when not being sampled.

Reset
REQ-018 rst=1 at an edge SHALL force the INIT state with counter=0, busy=1, init_calib=0, rd_data_valid=0, rd_data=0, cmd_dropped=0.
REQ-019 Reset in the middle of a burst SHALL abort it; read beats are not delivered, and write beats already written remain, with no later beats written.
REQ-020 Memory contents SHALL NOT be cleared by reset; initial contents are undefined.

Verification
REQ-021 Init: release reset with INIT_CYCLES=8 -> init_calib=0 and busy=1 for 8 cycles, then both flip; cmd_en in cycle 3 -> cmd_dropped pulse and no write.
REQ-022 Write then read: write at addr 0x20 beats 0x1111..., 0x2222..., 0x3333..., 0x4444..., mask 0; then read at 0x20 -> valid 4 cycles starting exactly 12 cycles after acceptance, same values in order.
REQ-023 Mask: with word 4 = 0xFFFF_FFFF_FFFF_FFFF, write beat 0 = 0 with data_mask=8'hF0 -> reading word 4 returns 0xFFFF_FFFF_0000_0000.
REQ-024 Wrap: write a burst at the last word (addr = 2^DEPTH_BITWIDTH-8) -> beats 1..3 land in words 0..2, and a read confirms this.
REQ-025 Busy drop: a read command followed by cmd_en during READ_WAIT -> second command ignored with cmd_dropped pulse; a command issued the first cycle busy=0 -> accepted.
REQ-026 Reset mid-read after beat 1 -> rd_data_valid=0 next cycle, INIT re-entered, and earlier-written data still intact after init.
